// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the data-memory arbiter: controller state encoding,
// requester port ids and the default response timeout.
// No ports; imported by mem_arb_if users, mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Port ids double as bit positions in the two-bit request/grant vectors.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if
// Bundles the two requester handshakes (instruction fetch and load/store),
// the memory command/response bus and the busy flag.
//   if_*  : IF read requester (req/addr in, gnt/rvalid/rdata/err out)
//   d_*   : load/store requester (req/we/addr/wdata in, gnt/rvalid/rdata/err out)
//   mem_* : single-port memory (read/write/addr/wdata out, rdata/ready in)
//   busy  : arbiter is in the middle of a transaction
// Modports:
//   master : the arbiter itself
//   slave  : the surrounding requesters and memory
interface mem_arb_if #(
    parameter int DW = 32,
    parameter int AW = 32
);

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          if_err;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_err;

    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          busy;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output busy
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Combinational two-way picker.
//   req[1:0]  : request vector, indexed by PORT_IF / PORT_D
//   last      : port granted most recently
//   prio_mode : 1 = D port has fixed priority, 0 = round-robin on ties
//   gnt[1:0]  : one-hot winner (all zero when nobody requests)
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       prio_mode,
    output logic [1:0] gnt
);

    // D wins when it is alone, when it has fixed priority, or when IF was
    // the last port served; otherwise IF takes whatever is left.
    always_comb begin
        gnt = 2'b00;
        if (req[PORT_D] && (prio_mode || !req[PORT_IF] || last == PORT_IF)) begin
            gnt[PORT_D] = 1'b1;
        end else if (req[PORT_IF]) begin
            gnt[PORT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port data memory between the instruction-fetch port and
// the load/store port. One transaction at a time: grant in IDLE, a one-cycle
// command in ISSUE, wait for mem_ready (or time out) in WAIT, and a one-cycle
// response strobe to the winner in RESP.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, drops any transaction in flight
//   bus : mem_arb_if master view (requesters, memory bus, busy)
// Parameters: DW/AW data and address widths, TIMEOUT wait cycles before an
// error response (1..255), D_PRIO 1 = D fixed priority, 0 = round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int D_PRIO  = 1
) (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.master bus
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    arb_state_t    state;
    logic          last;
    logic          lat_port;
    logic          lat_we;
    logic [7:0]    cnt;
    logic          mem_read_q;
    logic          mem_write_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          if_rvalid_q;
    logic          d_rvalid_q;
    logic [1:0]    pick_gnt;
    logic [1:0]    grant;
    logic          sel_d;
    logic          sel_we;

    mem_arb_pick u_pick (
        .req       ({bus.d_req, bus.if_req}),
        .last      (last),
        .prio_mode (D_PRIO != 0),
        .gnt       (pick_gnt)
    );

    // Grants are combinational but only exist in IDLE and never while reset
    // is held, so every output reads 0 during reset.
    assign grant  = (state == IDLE && !rst) ? pick_gnt : 2'b00;
    assign sel_d  = grant[PORT_D];
    assign sel_we = sel_d & bus.d_we;

    // The memory command registers double as the payload latch: they are
    // loaded on the grant, so the command appears exactly in the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= PORT_D;
            lat_port    <= PORT_IF;
            lat_we      <= 1'b0;
            cnt         <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        lat_port    <= sel_d;
                        last        <= sel_d;
                        lat_we      <= sel_we;
                        mem_read_q  <= !sel_we;
                        mem_write_q <= sel_we;
                        mem_addr_q  <= sel_d ? bus.d_addr : bus.if_addr;
                        mem_wdata_q <= sel_we ? bus.d_wdata : '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    cnt         <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (bus.mem_ready) begin
                        resp_rdata  <= lat_we ? '0 : bus.mem_rdata;
                        resp_err    <= 1'b0;
                        if_rvalid_q <= (lat_port == PORT_IF);
                        d_rvalid_q  <= (lat_port == PORT_D);
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == TIMEOUT_CNT) begin
                            resp_rdata  <= '0;
                            resp_err    <= 1'b1;
                            if_rvalid_q <= (lat_port == PORT_IF);
                            d_rvalid_q  <= (lat_port == PORT_D);
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if_rvalid_q <= 1'b0;
                    d_rvalid_q  <= 1'b0;
                    resp_rdata  <= '0;
                    resp_err    <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.if_gnt    = grant[PORT_IF];
    assign bus.d_gnt     = grant[PORT_D];
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = resp_rdata;
    assign bus.d_rdata   = resp_rdata;
    assign bus.if_err    = resp_err;
    assign bus.d_err     = resp_err;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Two arbiter instances: dut0 is round-robin with a short timeout and sits on
// a small registered memory model; dut1 has D fixed priority. Cycle vectors
// for dut0 list the inputs and the expected outputs for one clock each.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    logic mem_en;
    logic force_ready;
    int   checks = 0;
    int   errors = 0;

    mem_arb_if #(.DW(32), .AW(32)) bus0 ();
    mem_arb_if #(.DW(32), .AW(32)) bus1 ();

    mem_arbiter #(.DW(32), .AW(32), .TIMEOUT(3), .D_PRIO(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    mem_arbiter #(.DW(32), .AW(32), .TIMEOUT(15), .D_PRIO(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model for dut0: answers one cycle after the command unless
    // mem_en is low; force_ready injects stray ready pulses.
    logic [31:0] mem0 [0:255];
    logic        model_ready0;
    logic [31:0] model_rdata0;

    always @(posedge clk) begin
        if (rst) mem0[4] <= 32'hDEADBEEF;
        else if (bus0.mem_write) mem0[bus0.mem_addr[9:2]] <= bus0.mem_wdata;
        model_rdata0 <= mem0[bus0.mem_addr[9:2]];
        model_ready0 <= rst ? 1'b0 : ((bus0.mem_read | bus0.mem_write) & mem_en);
    end

    assign bus0.mem_ready = model_ready0 | force_ready;
    assign bus0.mem_rdata = model_rdata0;

    logic ready1;
    always @(posedge clk) ready1 <= rst ? 1'b0 : (bus1.mem_read | bus1.mem_write);
    assign bus1.mem_ready = ready1;
    assign bus1.mem_rdata = 32'hA5A50001;

    // exp bits: {if_gnt, d_gnt, mem_read, mem_write, if_rvalid, d_rvalid, busy}
    typedef struct {
        string       name;
        logic        rst;
        logic        if_req;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_en;
        logic        force_ready;
        logic [6:0]  exp;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t V(string nm, logic rs, logic ir, logic dr, logic dw,
                               logic [31:0] da, logic [31:0] dd, logic en, logic fr,
                               logic [6:0] ex, logic [31:0] ea, logic [31:0] ed, logic ee);
        vec_t v;
        v.name = nm; v.rst = rs; v.if_req = ir; v.d_req = dr; v.d_we = dw;
        v.d_addr = da; v.d_wdata = dd; v.mem_en = en; v.force_ready = fr;
        v.exp = ex; v.exp_addr = ea; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst          = v.rst;
        bus0.if_req  = v.if_req;
        bus0.if_addr = 32'h10;
        bus0.d_req   = v.d_req;
        bus0.d_we    = v.d_we;
        bus0.d_addr  = v.d_addr;
        bus0.d_wdata = v.d_wdata;
        mem_en       = v.mem_en;
        force_ready  = v.force_ready;
    endtask

    task automatic checkOutput(input vec_t v);
        check1({v.name, ".if_gnt"},    32'(bus0.if_gnt),    32'(v.exp[6]));
        check1({v.name, ".d_gnt"},     32'(bus0.d_gnt),     32'(v.exp[5]));
        check1({v.name, ".mem_read"},  32'(bus0.mem_read),  32'(v.exp[4]));
        check1({v.name, ".mem_write"}, 32'(bus0.mem_write), 32'(v.exp[3]));
        check1({v.name, ".if_rvalid"}, 32'(bus0.if_rvalid), 32'(v.exp[2]));
        check1({v.name, ".d_rvalid"},  32'(bus0.d_rvalid),  32'(v.exp[1]));
        check1({v.name, ".busy"},      32'(bus0.busy),      32'(v.exp[0]));
        if (v.exp[4] || v.exp[3]) check1({v.name, ".mem_addr"}, bus0.mem_addr, v.exp_addr);
        if (v.exp[3]) check1({v.name, ".mem_wdata"}, bus0.mem_wdata, v.exp_data);
        if (v.exp[2]) begin
            check1({v.name, ".if_rdata"}, bus0.if_rdata, v.exp_data);
            check1({v.name, ".if_err"}, 32'(bus0.if_err), 32'(v.exp_err));
        end
        if (v.exp[1]) begin
            check1({v.name, ".d_rdata"}, bus0.d_rdata, v.exp_data);
            check1({v.name, ".d_err"}, 32'(bus0.d_err), 32'(v.exp_err));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        mem_en = 1'b1;
        force_ready = 1'b0;
        bus0.if_req = 1'b0; bus0.if_addr = '0; bus0.d_req = 1'b0;
        bus0.d_we = 1'b0; bus0.d_addr = '0; bus0.d_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0;
        bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;

        // IF read, D write, D read back
        vecs.push_back(V("if_rd_c0", 0, 1, 0, 0, 32'h0,  32'h0,        1, 0, 7'b1000000, 32'h0,  32'h0,        0));
        vecs.push_back(V("if_rd_c1", 0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0010001, 32'h10, 32'h0,        0));
        vecs.push_back(V("if_rd_c2", 0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000001, 32'h0,  32'h0,        0));
        vecs.push_back(V("if_rd_c3", 0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000101, 32'h0,  32'hDEADBEEF, 0));
        vecs.push_back(V("d_wr_c0",  0, 0, 1, 1, 32'h20, 32'h12345678, 1, 0, 7'b0100000, 32'h0,  32'h0,        0));
        vecs.push_back(V("d_wr_c1",  0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0001001, 32'h20, 32'h12345678, 0));
        vecs.push_back(V("d_wr_c2",  0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000001, 32'h0,  32'h0,        0));
        vecs.push_back(V("d_wr_c3",  0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000011, 32'h0,  32'h0,        0));
        vecs.push_back(V("d_rd_c0",  0, 0, 1, 0, 32'h20, 32'h0,        1, 0, 7'b0100000, 32'h0,  32'h0,        0));
        vecs.push_back(V("d_rd_c1",  0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0010001, 32'h20, 32'h0,        0));
        vecs.push_back(V("d_rd_c2",  0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000001, 32'h0,  32'h0,        0));
        vecs.push_back(V("d_rd_c3",  0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000011, 32'h0,  32'h12345678, 0));
        // round-robin with both ports requesting; last grant was D
        vecs.push_back(V("rr1_c0",   0, 1, 1, 0, 32'h20, 32'h0,        1, 0, 7'b1000000, 32'h0,  32'h0,        0));
        vecs.push_back(V("rr1_c1",   0, 0, 1, 0, 32'h20, 32'h0,        1, 0, 7'b0010001, 32'h10, 32'h0,        0));
        vecs.push_back(V("rr1_c2",   0, 0, 1, 0, 32'h20, 32'h0,        1, 0, 7'b0000001, 32'h0,  32'h0,        0));
        vecs.push_back(V("rr1_c3",   0, 1, 1, 0, 32'h20, 32'h0,        1, 0, 7'b0000101, 32'h0,  32'hDEADBEEF, 0));
        vecs.push_back(V("rr2_c0",   0, 1, 1, 0, 32'h20, 32'h0,        1, 0, 7'b0100000, 32'h0,  32'h0,        0));
        vecs.push_back(V("rr2_c1",   0, 1, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0010001, 32'h20, 32'h0,        0));
        vecs.push_back(V("rr2_c2",   0, 1, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000001, 32'h0,  32'h0,        0));
        vecs.push_back(V("rr2_c3",   0, 1, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000011, 32'h0,  32'h12345678, 0));
        vecs.push_back(V("rr3_c0",   0, 1, 1, 0, 32'h20, 32'h0,        1, 0, 7'b1000000, 32'h0,  32'h0,        0));
        vecs.push_back(V("rr3_c1",   0, 0, 1, 0, 32'h20, 32'h0,        1, 0, 7'b0010001, 32'h10, 32'h0,        0));
        vecs.push_back(V("rr3_c2",   0, 0, 1, 0, 32'h20, 32'h0,        1, 0, 7'b0000001, 32'h0,  32'h0,        0));
        vecs.push_back(V("rr3_c3",   0, 0, 1, 0, 32'h20, 32'h0,        1, 0, 7'b0000101, 32'h0,  32'hDEADBEEF, 0));
        vecs.push_back(V("rr4_c0",   0, 1, 1, 0, 32'h20, 32'h0,        1, 0, 7'b0100000, 32'h0,  32'h0,        0));
        vecs.push_back(V("rr4_c1",   0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0010001, 32'h20, 32'h0,        0));
        vecs.push_back(V("rr4_c2",   0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000001, 32'h0,  32'h0,        0));
        vecs.push_back(V("rr4_c3",   0, 0, 1, 0, 32'h20, 32'h0,        1, 0, 7'b0000011, 32'h0,  32'h12345678, 0));
        // timeout with stray ready pulses in IDLE and ISSUE
        vecs.push_back(V("to_c0",    0, 0, 1, 0, 32'h20, 32'h0,        0, 1, 7'b0100000, 32'h0,  32'h0,        0));
        vecs.push_back(V("to_c1",    0, 0, 0, 0, 32'h0,  32'h0,        0, 1, 7'b0010001, 32'h20, 32'h0,        0));
        vecs.push_back(V("to_c2",    0, 0, 0, 0, 32'h0,  32'h0,        0, 0, 7'b0000001, 32'h0,  32'h0,        0));
        vecs.push_back(V("to_c3",    0, 0, 0, 0, 32'h0,  32'h0,        0, 0, 7'b0000001, 32'h0,  32'h0,        0));
        vecs.push_back(V("to_c4",    0, 0, 0, 0, 32'h0,  32'h0,        0, 0, 7'b0000001, 32'h0,  32'h0,        0));
        vecs.push_back(V("to_c5",    0, 0, 0, 0, 32'h0,  32'h0,        0, 0, 7'b0000011, 32'h0,  32'h0,        1));
        vecs.push_back(V("to_c6",    0, 0, 1, 0, 32'h20, 32'h0,        1, 0, 7'b0100000, 32'h0,  32'h0,        0));
        vecs.push_back(V("to_n1",    0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0010001, 32'h20, 32'h0,        0));
        vecs.push_back(V("to_n2",    0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000001, 32'h0,  32'h0,        0));
        vecs.push_back(V("to_n3",    0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000011, 32'h0,  32'h12345678, 0));
        // reset while waiting, then a fresh request
        vecs.push_back(V("rst_c0",   0, 0, 1, 0, 32'h20, 32'h0,        1, 0, 7'b0100000, 32'h0,  32'h0,        0));
        vecs.push_back(V("rst_c1",   0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0010001, 32'h20, 32'h0,        0));
        vecs.push_back(V("rst_c2",   1, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000001, 32'h0,  32'h0,        0));
        vecs.push_back(V("rst_c3",   0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000000, 32'h0,  32'h0,        0));
        vecs.push_back(V("rst_c4",   0, 0, 1, 0, 32'h20, 32'h0,        1, 0, 7'b0100000, 32'h0,  32'h0,        0));
        vecs.push_back(V("rst_c5",   0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0010001, 32'h20, 32'h0,        0));
        vecs.push_back(V("rst_c6",   0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000001, 32'h0,  32'h0,        0));
        vecs.push_back(V("rst_c7",   0, 0, 0, 0, 32'h0,  32'h0,        1, 0, 7'b0000011, 32'h0,  32'h12345678, 0));

        // reset values, sampled while reset is still held
        repeat (2) @(negedge clk);
        #2;
        check1("reset.if_gnt",    32'(bus0.if_gnt),    32'h0);
        check1("reset.d_gnt",     32'(bus0.d_gnt),     32'h0);
        check1("reset.mem_read",  32'(bus0.mem_read),  32'h0);
        check1("reset.mem_write", 32'(bus0.mem_write), 32'h0);
        check1("reset.mem_addr",  bus0.mem_addr,       32'h0);
        check1("reset.if_rvalid", 32'(bus0.if_rvalid), 32'h0);
        check1("reset.d_rvalid",  32'(bus0.d_rvalid),  32'h0);
        check1("reset.d_rdata",   bus0.d_rdata,        32'h0);
        check1("reset.busy",      32'(bus0.busy),      32'h0);
        check1("reset.dut1_busy", 32'(bus1.busy),      32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            checkOutput(vecs[i]);
        end

        // fixed D priority: IF starves while D keeps requesting
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus1.if_req  = (k <= 12);
            bus1.if_addr = 32'h44;
            bus1.d_req   = (k < 12);
            bus1.d_we    = 1'b0;
            bus1.d_addr  = 32'h40;
            #2;
            check1($sformatf("prio_k%0d.d_gnt", k),     32'(bus1.d_gnt),     32'(k < 12 && k % 4 == 0));
            check1($sformatf("prio_k%0d.if_gnt", k),    32'(bus1.if_gnt),    32'(k == 12));
            check1($sformatf("prio_k%0d.d_rvalid", k),  32'(bus1.d_rvalid),  32'(k < 12 && k % 4 == 3));
            check1($sformatf("prio_k%0d.if_rvalid", k), 32'(bus1.if_rvalid), 32'(k == 15));
            if (k < 12 && k % 4 == 3) check1($sformatf("prio_k%0d.d_rdata", k), bus1.d_rdata, 32'hA5A50001);
            if (k == 15) check1("prio_k15.if_rdata", bus1.if_rdata, 32'hA5A50001);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
